// File: rtl/risp_input_stage.sv
// -----------------------------------------------------------------------------
// risp_input_stage
//
// Upstream feeder for the RISP neuron array. Host spike packets (target input
// index + signed charge) arrive on a valid/ready stream and are summed, with
// saturation, into one accumulator per network input. A step packet launches
// one or more network timesteps (net_en pulses). The accumulated charges are
// shown on net_inp during the first timestep of the command only, and the
// accumulators are cleared when that first timestep fires.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous reset, active-high
//   s_valid    packet valid
//   s_ready    packet accepted when s_valid && s_ready (high only in ACCUM)
//   s_step     1 = step command, 0 = charge packet
//   s_idx      target input index of a charge packet
//   s_charge   signed charge of a charge packet
//   s_run      number of timesteps of a step command (0 = no-op)
//   net_ready  network can take a timestep this cycle
//   net_en     network timestep enable, one cycle per timestep
//   net_inp    per-input charges presented to the network
//   busy       high while a step command is executing
//   step_cnt   timesteps completed since reset (wraps)
//   err_idx    sticky flag: a charge packet targeted a non-existent input
// -----------------------------------------------------------------------------
module risp_input_stage #(
    parameter int NUM_INP      = 8,
    parameter int CHARGE_WIDTH = 8,
    parameter int RUN_WIDTH    = 8,
    parameter int CNT_WIDTH    = 32,
    localparam int IDX_WIDTH   = (NUM_INP > 1) ? $clog2(NUM_INP) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           s_step,
    input  logic [IDX_WIDTH-1:0]           s_idx,
    input  logic signed [CHARGE_WIDTH-1:0] s_charge,
    input  logic [RUN_WIDTH-1:0]           s_run,
    input  logic                           net_ready,
    output logic                           net_en,
    output logic signed [CHARGE_WIDTH-1:0] net_inp [0:NUM_INP-1],
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           step_cnt,
    output logic                           err_idx
);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_STEP  = 1'b1;

    localparam int CW = CHARGE_WIDTH;

    logic [0:0]           state_reg;
    logic [RUN_WIDTH-1:0] remaining_reg;
    logic                 first_reg;
    logic [CNT_WIDTH-1:0] step_cnt_reg;
    logic                 err_idx_reg;

    logic accept;
    logic idx_valid;
    logic acc_charge;
    logic clear_acc;

    // Handshake and step enable are pure decodes of the state so that net_en
    // follows net_ready in the same cycle.
    assign s_ready    = (state_reg == ST_ACCUM);
    assign busy       = (state_reg == ST_STEP);
    assign net_en     = busy && net_ready;
    assign accept     = s_valid && s_ready;
    assign acc_charge = accept && !s_step && idx_valid;
    // Accumulators are consumed by the first timestep of a command.
    assign clear_acc  = net_en && first_reg;

    assign step_cnt = step_cnt_reg;
    assign err_idx  = err_idx_reg;

    // Range check only exists when the index field can encode more values
    // than there are inputs; otherwise every index is legal.
    generate
        if ((1 << IDX_WIDTH) > NUM_INP) begin : g_idx_chk
            localparam logic [IDX_WIDTH:0] NUM_INP_W = (IDX_WIDTH+1)'(NUM_INP);
            assign idx_valid = ({1'b0, s_idx} < NUM_INP_W);
        end else begin : g_idx_full
            assign idx_valid = 1'b1;
        end
    endgenerate

    // One accumulator per network input. All of them must be readable in
    // parallel on the first timestep, so they live in flops, not RAM.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INP; gi++) begin : g_chan
            logic signed [CW-1:0] acc_reg;
            logic signed [CW:0]   sum;
            logic signed [CW-1:0] sat;
            logic                 hit;

            // One extra bit of headroom: an overflow shows up as the two
            // top bits of the sum disagreeing.
            assign sum = {acc_reg[CW-1], acc_reg} + {s_charge[CW-1], s_charge};
            assign hit = acc_charge && (s_idx == IDX_WIDTH'(gi));

            always_comb begin
                sat = sum[CW-1:0];
                if (sum[CW] != sum[CW-1]) begin
                    sat = sum[CW] ? {1'b1, {(CW-1){1'b0}}}
                                  : {1'b0, {(CW-1){1'b1}}};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg <= '0;
                end else if (clear_acc) begin
                    acc_reg <= '0;
                end else if (hit) begin
                    acc_reg <= sat;
                end
            end

            // Charges are driven only while the first timestep is pending, so
            // a neuron that fires combinationally never sees stray charge.
            assign net_inp[gi] = (busy && first_reg) ? acc_reg : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_ACCUM;
            remaining_reg <= '0;
            first_reg     <= 1'b0;
            step_cnt_reg  <= '0;
            err_idx_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_ACCUM: begin
                    if (accept) begin
                        if (s_step) begin
                            // A zero-length run is consumed without effect.
                            if (s_run != '0) begin
                                remaining_reg <= s_run;
                                first_reg     <= 1'b1;
                                state_reg     <= ST_STEP;
                            end
                        end else if (!idx_valid) begin
                            err_idx_reg <= 1'b1;
                        end
                    end
                end
                ST_STEP: begin
                    if (net_en) begin
                        remaining_reg <= remaining_reg - RUN_WIDTH'(1);
                        step_cnt_reg  <= step_cnt_reg + CNT_WIDTH'(1);
                        first_reg     <= 1'b0;
                        if (remaining_reg == RUN_WIDTH'(1)) begin
                            state_reg <= ST_ACCUM;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risp_input_stage.sv
// -----------------------------------------------------------------------------
// tb_risp_input_stage
//
// Directed bench for risp_input_stage. The DUT is built with six inputs so the
// 3-bit index field can carry indices (6, 7) that name no input, which is what
// exercises err_idx. Inputs are driven on the falling edge and outputs are
// checked 1 ns after it, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_risp_input_stage;

    localparam int NUM  = 6;
    localparam int CW   = 8;
    localparam int RW   = 8;
    localparam int CNTW = 32;
    localparam int IW   = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic                 s_step;
    logic [IW-1:0]        s_idx;
    logic signed [CW-1:0] s_charge;
    logic [RW-1:0]        s_run;
    logic                 net_ready;
    logic                 net_en;
    logic signed [CW-1:0] net_inp [0:NUM-1];
    logic                 busy;
    logic [CNTW-1:0]      step_cnt;
    logic                 err_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    risp_input_stage #(
        .NUM_INP      (NUM),
        .CHARGE_WIDTH (CW),
        .RUN_WIDTH    (RW),
        .CNT_WIDTH    (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_step    (s_step),
        .s_idx     (s_idx),
        .s_charge  (s_charge),
        .s_run     (s_run),
        .net_ready (net_ready),
        .net_en    (net_en),
        .net_inp   (net_inp),
        .busy      (busy),
        .step_cnt  (step_cnt),
        .err_idx   (err_idx)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Checks all outputs of the current cycle against hand-computed values.
    task automatic status(input string tag, input int en, input int rdy, input int bsy,
                          input longint cnt, input int e0, input int e1, input int e2,
                          input int e3, input int e4, input int e5);
        int exp_inp [0:NUM-1];
        exp_inp = '{e0, e1, e2, e3, e4, e5};
        #1;
        check({tag, ".net_en"},   longint'(net_en),   longint'(en));
        check({tag, ".s_ready"},  longint'(s_ready),  longint'(rdy));
        check({tag, ".busy"},     longint'(busy),     longint'(bsy));
        check({tag, ".step_cnt"}, longint'(step_cnt), cnt);
        for (int i = 0; i < NUM; i++) begin
            check($sformatf("%s.net_inp%0d", tag, i), longint'(net_inp[i]), longint'(exp_inp[i]));
        end
    endtask

    // Presents one packet for exactly one rising edge; call just after a
    // falling edge. Consecutive calls give back-to-back packets.
    task automatic pkt(input logic step, input int idx, input int charge, input int run);
        s_valid  = 1'b1;
        s_step   = step;
        s_idx    = IW'(idx);
        s_charge = CW'(charge);
        s_run    = RW'(run);
        $display("pkt step=%0d idx=%0d charge=%0d run=%0d", step, idx, charge, run);
        @(negedge clk);
        s_valid  = 1'b0;
        s_step   = 1'b0;
        s_idx    = '0;
        s_charge = '0;
        s_run    = '0;
    endtask

    initial begin
        int pat [0:3];
        int cnt_exp [0:3];

        rst       = 1'b1;
        s_valid   = 1'b0;
        s_step    = 1'b0;
        s_idx     = '0;
        s_charge  = '0;
        s_run     = '0;
        net_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        status("reset", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset.err_idx", longint'(err_idx), 0);

        // 1: basic accumulation, single step
        pkt(1'b0, 1, 3, 0);
        pkt(1'b0, 1, 4, 0);
        pkt(1'b0, 0, -2, 0);
        pkt(1'b1, 0, 0, 1);
        status("t1_fire", 1, 0, 1, 0, -2, 7, 0, 0, 0, 0);
        @(negedge clk);
        status("t1_done", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);

        // 2: saturation both directions
        pkt(1'b0, 0, 100, 0);
        pkt(1'b0, 0, 100, 0);
        pkt(1'b0, 2, -100, 0);
        pkt(1'b0, 2, -100, 0);
        pkt(1'b1, 0, 0, 1);
        status("t2_fire", 1, 0, 1, 1, 127, 0, -128, 0, 0, 0);
        @(negedge clk);
        status("t2_done", 0, 1, 0, 2, 0, 0, 0, 0, 0, 0);

        // 3: three-step command with a stall cycle
        pat     = '{1, 0, 1, 1};
        cnt_exp = '{2, 3, 3, 4};
        pkt(1'b0, 3, 5, 0);
        pkt(1'b1, 0, 0, 3);
        for (int k = 0; k < 4; k++) begin
            net_ready = pat[k][0];
            status($sformatf("t3_c%0d", k + 1), pat[k], 0, 1, longint'(cnt_exp[k]),
                   0, 0, 0, (k == 0) ? 5 : 0, 0, 0);
            @(negedge clk);
        end
        net_ready = 1'b1;
        status("t3_done", 0, 1, 0, 5, 0, 0, 0, 0, 0, 0);

        // 4: out-of-range indices set the sticky error and touch nothing
        pkt(1'b0, 6, 9, 0);
        pkt(1'b0, 7, 9, 0);
        #1;
        check("t4_err", longint'(err_idx), 1);
        pkt(1'b1, 0, 0, 1);
        status("t4_fire", 1, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        status("t4_done", 0, 1, 0, 6, 0, 0, 0, 0, 0, 0);
        check("t4_err_sticky", longint'(err_idx), 1);
        pkt(1'b0, 5, 1, 0);
        pkt(1'b1, 0, 0, 1);
        status("t4_last_fire", 1, 0, 1, 6, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        status("t4_last_done", 0, 1, 0, 7, 0, 0, 0, 0, 0, 0);

        // 5: zero-length step is a no-op; charges held while net_ready is low
        pkt(1'b0, 0, 4, 0);
        pkt(1'b1, 0, 0, 0);
        status("t5_noop", 0, 1, 0, 7, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        status("t5_idle", 0, 1, 0, 7, 0, 0, 0, 0, 0, 0);
        net_ready = 1'b0;
        pkt(1'b1, 0, 0, 1);
        status("t5_wait1", 0, 0, 1, 7, 4, 0, 0, 0, 0, 0);
        @(negedge clk);
        status("t5_wait2", 0, 0, 1, 7, 4, 0, 0, 0, 0, 0);
        net_ready = 1'b1;
        status("t5_fire", 1, 0, 1, 7, 4, 0, 0, 0, 0, 0);
        @(negedge clk);
        status("t5_done", 0, 1, 0, 8, 0, 0, 0, 0, 0, 0);

        // 6: reset aborts a running command
        pkt(1'b0, 0, 4, 0);
        pkt(1'b1, 0, 0, 3);
        status("t6_fire", 1, 0, 1, 8, 4, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        status("t6_rst", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6_err", longint'(err_idx), 0);
        @(negedge clk);
        status("t6_idle", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        pkt(1'b1, 0, 0, 1);
        status("t6_fire2", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        status("t6_done", 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
